power_pack_pool: RTL and testbench

Multi-slot power-up manager for the Pong playfield. Holds up to `N_SLOTS` independent power packs, each with its own position, mode, colour and lifetime. Allocates spawns to free slots, retires packs on collision with the ball or on timeout, and drives an 8-bit RGB332 pixel stream into the VGA mixer alongside the paddle and ball layers. Random position and mode come from the existing LFSR generators upstream.

---
 rtl/power_pack_pkg.sv | 28 ++
 rtl/power_pack_slot.sv | 97 +++++++++
 rtl/power_pack_pool.sv | 132 +++++++++++++
 tb/tb_power_pack_pool.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_pack_pkg.sv
// power_pack_pkg: pack modes, slot states and mode-to-colour lookup for the power pack pool
package power_pack_pkg;

  typedef enum logic [1:0] {
    MODE_SHRINK = 2'd0,
    MODE_BOOST  = 2'd1,
    MODE_EXTRA  = 2'd2,
    MODE_SHIELD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_BLINK  = 2'd2
  } slot_state_e;

  localparam logic [7:0] COLOR_SHRINK = 8'h03;
  localparam logic [7:0] COLOR_BOOST  = 8'h16;
  localparam logic [7:0] COLOR_EXTRA  = 8'hE3;
  localparam logic [7:0] COLOR_SHIELD = 8'hF0;

  function automatic logic [7:0] mode_color(mode_e m);
    return m == MODE_SHRINK ? COLOR_SHRINK :
           m == MODE_BOOST  ? COLOR_BOOST  :
           m == MODE_EXTRA  ? COLOR_EXTRA  : COLOR_SHIELD;
  endfunction

endpackage

// File: rtl/power_pack_slot.sv
// power_pack_slot: one pack's FSM, lifetime counter, ball overlap and pixel coverage (blink stage under POWER_PACK_BLINK_EN)
module power_pack_slot
  import power_pack_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int HEIGHT    = 20,
  parameter int LIFETIME  = 600,
  parameter int BALL_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick_i,
  input  logic        load_i,
  input  logic        kill_i,
  input  logic [10:0] load_x_i,
  input  logic [9:0]  load_y_i,
  input  mode_e       load_mode_i,
  input  logic [10:0] ball_x_i,
  input  logic [9:0]  ball_y_i,
  input  logic [10:0] hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic        blink_off_i,
  output logic        busy_o,
  output logic        overlap_o,
  output logic        covers_o,
  output mode_e       mode_o
);

  localparam int LW = $clog2(LIFETIME + 1);

  slot_state_e   state_q, state_d;
  logic [LW-1:0] life_q, life_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  mode_e         mode_q, mode_d;
  logic [11:0]   px, bx, hx;
  logic [10:0]   py, by, vy;
  logic          visible;

  assign px = {1'b0, x_q};
  assign bx = {1'b0, ball_x_i};
  assign hx = {1'b0, hcount_i};
  assign py = {1'b0, y_q};
  assign by = {1'b0, ball_y_i};
  assign vy = {1'b0, vcount_i};

  assign busy_o    = state_q != SLOT_IDLE;
  assign visible   = state_q == SLOT_ACTIVE || (state_q == SLOT_BLINK && !blink_off_i);
  assign overlap_o = busy_o && bx < px + 12'(WIDTH) && px < bx + 12'(BALL_SIZE) &&
                     by < py + 11'(HEIGHT) && py < by + 11'(BALL_SIZE);
  assign covers_o  = visible && hx >= px && hx < px + 12'(WIDTH) && vy >= py && vy < py + 11'(HEIGHT);
  assign mode_o    = mode_q;

  // Next state: allocation, then collision retire, then per-frame ageing with timeout
  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    if (load_i) begin
      state_d = SLOT_ACTIVE;
      life_d  = LW'(LIFETIME);
      x_d     = load_x_i;
      y_d     = load_y_i;
      mode_d  = load_mode_i;
    end else if (kill_i) begin
      state_d = SLOT_IDLE;
    end else if (busy_o && frame_tick_i) begin
      life_d = life_q - LW'(1);
      if (life_q <= LW'(1))
        state_d = SLOT_IDLE;
`ifdef POWER_PACK_BLINK_EN
      else if (life_d <= LW'(LIFETIME / 4))
        state_d = SLOT_BLINK;
`endif
    end
  end

  // Slot state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SLOT_IDLE;
      life_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= MODE_SHRINK;
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: rtl/power_pack_pool.sv
// power_pack_pool: multi-slot power-up manager with allocation, collision retire and RGB332 pixel output (blink via POWER_PACK_BLINK_EN)
module power_pack_pool
  import power_pack_pkg::*;
#(
  parameter int N_SLOTS   = 4,
  parameter int WIDTH     = 20,
  parameter int HEIGHT    = 20,
  parameter int H_MAX     = 1024,
  parameter int V_MAX     = 768,
  parameter int LIFETIME  = 600,
  parameter int BALL_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic [10:0] spawn_x,
  input  logic [9:0]  spawn_y,
  input  logic [1:0]  spawn_mode,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [7:0]  pixel,
  output logic        hit,
  output logic [1:0]  hit_mode,
  output logic [2:0]  hit_slot,
  output logic        spawn_ack,
  output logic        spawn_drop,
  output logic [3:0]  active_cnt
);

  localparam logic [10:0] X_LIM = 11'(H_MAX - WIDTH);
  localparam logic [9:0]  Y_LIM = 10'(V_MAX - HEIGHT);

  logic [N_SLOTS-1:0] busy, overlap, covers, load, kill;
  mode_e              slot_mode [N_SLOTS];
  logic [10:0]        load_x;
  logic [9:0]         load_y;
  logic               free_any, col_any;
  logic [2:0]         free_idx, col_idx;
  mode_e              col_mode;
  logic [7:0]         pixel_d, pixel_q;
  logic [3:0]         cnt, frame_q;
  logic               hit_q, ack_q, drop_q;
  logic [1:0]         hit_mode_q;
  logic [2:0]         hit_slot_q;

  assign load_x = spawn_x > X_LIM ? X_LIM : spawn_x;
  assign load_y = spawn_y > Y_LIM ? Y_LIM : spawn_y;

  for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
    assign load[s] = spawn && free_any && free_idx == 3'(s);
    assign kill[s] = col_any && col_idx == 3'(s);
    power_pack_slot #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LIFETIME(LIFETIME), .BALL_SIZE(BALL_SIZE)
    ) u_slot (
      .clk(clk),
      .reset(reset),
      .frame_tick_i(frame_tick),
      .load_i(load[s]),
      .kill_i(kill[s]),
      .load_x_i(load_x),
      .load_y_i(load_y),
      .load_mode_i(mode_e'(spawn_mode)),
      .ball_x_i(ball_x),
      .ball_y_i(ball_y),
      .hcount_i(hcount),
      .vcount_i(vcount),
      .blink_off_i(frame_q[3]),
      .busy_o(busy[s]),
      .overlap_o(overlap[s]),
      .covers_o(covers[s]),
      .mode_o(slot_mode[s])
    );
  end

  // Lowest-index priority for free slot, collision and pixel; scanning downward lets the lowest index win
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    col_any  = 1'b0;
    col_idx  = '0;
    col_mode = MODE_SHRINK;
    pixel_d  = '0;
    cnt      = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = 3'(i);
      end
      if (overlap[i]) begin
        col_any  = 1'b1;
        col_idx  = 3'(i);
        col_mode = slot_mode[i];
      end
      if (covers[i])
        pixel_d = mode_color(slot_mode[i]);
      cnt = cnt + 4'(busy[i]);
    end
  end

  // Registered outputs and the frame counter that drives blinking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_q    <= '0;
      hit_q      <= 1'b0;
      hit_mode_q <= '0;
      hit_slot_q <= '0;
      ack_q      <= 1'b0;
      drop_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      pixel_q    <= pixel_d;
      hit_q      <= col_any;
      hit_mode_q <= col_any ? col_mode : MODE_SHRINK;
      hit_slot_q <= col_any ? col_idx : '0;
      ack_q      <= spawn && free_any;
      drop_q     <= spawn && !free_any;
      frame_q    <= frame_q + 4'(frame_tick);
    end
  end

  assign pixel      = pixel_q;
  assign hit        = hit_q;
  assign hit_mode   = hit_mode_q;
  assign hit_slot   = hit_slot_q;
  assign spawn_ack  = ack_q;
  assign spawn_drop = drop_q;
  assign active_cnt = cnt;

endmodule

// File: tb/tb_power_pack_pool.sv
// tb_power_pack_pool: directed and randomized checks of power_pack_pool against a frame-level pool model
module tb_power_pack_pool;

  localparam int LT = 8;

  logic        clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, spawn = 1'b0;
  logic [10:0] spawn_x = '0, ball_x = 11'd2000, hcount = '0;
  logic [9:0]  spawn_y = '0, ball_y = 10'd1000, vcount = '0;
  logic [1:0]  spawn_mode = '0;
  logic [7:0]  pixel;
  logic        hit, spawn_ack, spawn_drop;
  logic [1:0]  hit_mode;
  logic [2:0]  hit_slot;
  logic [3:0]  active_cnt;

  int checks = 0, errors = 0;
  bit mb[4];
  int mx[4], my[4], mm[4], ml[4];
  int frames = 0;
  int e_pix = 0, e_hit = 0, e_hmode = 0, e_hslot = 0, e_ack = 0, e_drop = 0, e_cnt = 0;
  int acks, drops;

  always #5 clk = ~clk;

  power_pack_pool #(.LIFETIME(LT)) dut (
    .clk(clk), .reset(rst_n), .frame_tick(frame_tick), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_mode(spawn_mode),
    .ball_x(ball_x), .ball_y(ball_y), .hcount(hcount), .vcount(vcount),
    .pixel(pixel), .hit(hit), .hit_mode(hit_mode), .hit_slot(hit_slot),
    .spawn_ack(spawn_ack), .spawn_drop(spawn_drop), .active_cnt(active_cnt)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int colour(int m);
    case (m)
      0: return 8'h03;
      1: return 8'h16;
      2: return 8'hE3;
      default: return 8'hF0;
    endcase
  endfunction

  function automatic bit blinking(int life);
`ifdef POWER_PACK_BLINK_EN
    return life <= LT / 4;
`else
    return life < 0;
`endif
  endfunction

  task automatic model_step();
    int ci, fi, pc, bx, by, h, v;
    if (!rst_n) begin
      foreach (mb[i]) mb[i] = 0;
      frames = 0;
      e_pix = 0; e_hit = 0; e_hmode = 0; e_hslot = 0; e_ack = 0; e_drop = 0; e_cnt = 0;
      return;
    end
    bx = ball_x; by = ball_y; h = hcount; v = vcount;
    ci = -1; fi = -1; pc = 0;
    for (int i = 3; i >= 0; i--) begin
      if (mb[i] && bx < mx[i] + 20 && mx[i] < bx + 16 && by < my[i] + 20 && my[i] < by + 16) ci = i;
      if (!mb[i]) fi = i;
      if (mb[i] && h >= mx[i] && h < mx[i] + 20 && v >= my[i] && v < my[i] + 20 &&
          !(blinking(ml[i]) && frames >= 8)) pc = colour(mm[i]);
    end
    e_pix = pc;
    e_hit = ci >= 0;
    e_hmode = 0; e_hslot = 0;
    if (ci >= 0) begin
      e_hmode = mm[ci];
      e_hslot = ci;
    end
    e_ack  = spawn && fi >= 0;
    e_drop = spawn && fi < 0;
    for (int i = 0; i < 4; i++)
      if (mb[i] && i != ci && frame_tick) begin
        ml[i]--;
        if (ml[i] == 0) mb[i] = 0;
      end
    if (ci >= 0) mb[ci] = 0;
    if (spawn && fi >= 0) begin
      mb[fi] = 1;
      mx[fi] = spawn_x > 1004 ? 1004 : int'(spawn_x);
      my[fi] = spawn_y > 748 ? 748 : int'(spawn_y);
      mm[fi] = spawn_mode;
      ml[fi] = LT;
    end
    if (frame_tick) frames = (frames + 1) % 16;
    e_cnt = 0;
    foreach (mb[i]) e_cnt += mb[i];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("pixel", pixel, e_pix);
    chk("hit", hit, e_hit);
    if (e_hit != 0) begin
      chk("hit_mode", hit_mode, e_hmode);
      chk("hit_slot", hit_slot, e_hslot);
    end
    chk("spawn_ack", spawn_ack, e_ack);
    chk("spawn_drop", spawn_drop, e_drop);
    chk("active_cnt", active_cnt, e_cnt);
  end

  task automatic do_spawn(int x, int y, int m);
    spawn = 1'b1;
    spawn_x = 11'(x);
    spawn_y = 10'(y);
    spawn_mode = 2'(m);
  endtask

  task automatic put_ball(int x, int y);
    ball_x = 11'(x);
    ball_y = 10'(y);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pixel", pixel, 0);
    chk("rst_hit", hit, 0);
    chk("rst_ack", spawn_ack, 0);
    chk("rst_cnt", active_cnt, 0);
    rst_n = 1'b1;
    do_spawn(300, 200, 1);
    @(negedge clk);
    spawn = 1'b0; hcount = 11'd305; vcount = 10'd210;
    chk("first_ack", spawn_ack, 1);
    chk("first_cnt", active_cnt, 1);
    chk("model_first_cnt", e_cnt, 1);
    @(negedge clk);
    chk("boost_pixel", pixel, 8'h16);
    chk("model_boost_pixel", e_pix, 8'h16);
    put_ball(310, 205);
    @(negedge clk);
    chk("eat_hit", hit, 1);
    chk("eat_mode", hit_mode, 1);
    chk("eat_slot", hit_slot, 0);
    chk("eat_cnt", active_cnt, 0);
    put_ball(2000, 1000);
    @(negedge clk);
    chk("eaten_pixel", pixel, 0);
    acks = 0; drops = 0;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: do_spawn(100, 100, 0);
        1: do_spawn(110, 105, 1);
        2: do_spawn(1020, 760, 2);
        3: do_spawn(600, 50, 3);
        default: do_spawn(50, 50, 1);
      endcase
      @(negedge clk);
      acks += spawn_ack;
      drops += spawn_drop;
    end
    spawn = 1'b0;
    chk("fill_acks", acks, 4);
    chk("fill_drops", drops, 1);
    chk("fill_last_drop", spawn_drop, 1);
    chk("fill_cnt", active_cnt, 4);
    hcount = 11'd1004; vcount = 10'd748;
    @(negedge clk);
    chk("clamp_pixel", pixel, 8'hE3);
    hcount = 11'd1003;
    @(negedge clk);
    chk("clamp_left_pixel", pixel, 0);
    hcount = 11'd115; vcount = 10'd110;
    @(negedge clk);
    chk("priority_pixel", pixel, 8'h03);
    put_ball(108, 108);
    @(negedge clk);
    chk("dual_hit0", hit, 1);
    chk("dual_slot0", hit_slot, 0);
    @(negedge clk);
    chk("dual_hit1", hit, 1);
    chk("dual_slot1", hit_slot, 1);
    chk("dual_mode1", hit_mode, 1);
    chk("dual_cnt", active_cnt, 2);
    put_ball(1000, 740);
    @(negedge clk);
    chk("edge_slot", hit_slot, 2);
    put_ball(600, 50);
    @(negedge clk);
    chk("shield_mode", hit_mode, 3);
    chk("empty_cnt", active_cnt, 0);
    put_ball(2000, 1000);
    do_spawn(200, 200, 3);
    @(negedge clk);
    put_ball(205, 205);
    do_spawn(500, 500, 0);
    @(negedge clk);
    chk("same_cycle_hit", hit, 1);
    chk("same_cycle_slot", hit_slot, 0);
    chk("same_cycle_ack", spawn_ack, 1);
    chk("same_cycle_cnt", active_cnt, 1);
    put_ball(2000, 1000);
    do_spawn(700, 300, 2);
    @(negedge clk);
    spawn = 1'b0; hcount = 11'd705; vcount = 10'd305;
    chk("reuse_cnt", active_cnt, 2);
    @(negedge clk);
    chk("reuse_pixel", pixel, 8'hE3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_cnt", active_cnt, 0);
    chk("async_rst_pixel", pixel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
    do_spawn(300, 200, 0);
    @(negedge clk);
    spawn = 1'b0; hcount = 11'd305; vcount = 10'd210;
    for (int k = 1; k <= 8; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      if (k == 5) chk("life5_pixel", pixel, 8'h03);
`ifdef POWER_PACK_BLINK_EN
      if (k == 6) chk("life6_blink_pixel", pixel, 0);
`else
      if (k == 6) chk("life6_pixel", pixel, 8'h03);
`endif
      if (k == 7) chk("life7_cnt", active_cnt, 1);
      if (k == 8) begin
        chk("life8_cnt", active_cnt, 0);
        chk("life8_hit", hit, 0);
      end
    end
    for (int k = 0; k < 3000; k++) begin
      spawn = $urandom_range(2) == 0;
      spawn_x = 11'($urandom_range(1100, 900));
      spawn_y = 10'($urandom_range(800, 690));
      spawn_mode = 2'($urandom);
      frame_tick = $urandom_range(7) == 0;
      if ($urandom_range(3) == 0)
        put_ball(int'($urandom_range(1030, 880)), int'($urandom_range(780, 680)));
      else
        put_ball(2000, 1000);
      hcount = 11'($urandom_range(1050, 890));
      vcount = 10'($urandom_range(780, 690));
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    spawn = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
